// File: rtl/aes_inv_key_schedule.sv
// On-the-fly inverse AES key schedule: expands forward to the last round key,
// then walks an Nk-word window backward and hands out round keys Nr down to 0.
module aes_inv_key_schedule (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LOAD,
    input  logic [1:0]   mode,
    input  logic [0:255] in_key,
    output logic [0:127] key_out,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EXPAND, DELIVER, STEP} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t      state;
    logic [31:0] window [0:7];
    logic [31:0] next_window [0:7];
    logic [5:0]  j;
    logic [2:0]  nk_m1;
    logic [3:0]  nr;
    logic [1:0]  step_cnt;
    logic [31:0] f_x;
    logic [31:0] f_out;
    logic [31:0] new_word;
    logic [5:0]  f_i;
    logic [5:0]  last_j;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Schedule function for word index i; the quotient selects the round constant.
    function automatic logic [31:0] key_fn(input logic [31:0] x, input logic [5:0] i,
                                           input logic [2:0] nkm1);
        logic [3:0] quo;
        logic [2:0] rem;
        case (nkm1)
            3'd3: begin
                quo = 4'(i >> 2);
                rem = {1'b0, i[1:0]};
            end
            3'd5: begin
                quo = 4'(i / 6'd6);
                rem = 3'(i % 6'd6);
            end
            default: begin
                quo = 4'(i >> 3);
                rem = i[2:0];
            end
        endcase
        if (rem == 3'd0)
            return sub_word({x[23:0], x[31:24]}) ^ {rcon(quo - 4'd1), 24'h0};
        else if (nkm1 == 3'd7 && rem == 3'd4)
            return sub_word(x);
        else
            return x;
    endfunction

    assign last_j = {nr, 2'b00};
    assign busy   = (state != IDLE);

    // One shared key function: forward in EXPAND, backward in STEP.
    always_comb begin
        if (state == STEP) begin
            f_x = window[nk_m1 - 3'd1];
            f_i = j + {3'd0, nk_m1};
        end else begin
            f_x = window[nk_m1];
            f_i = j + {3'd0, nk_m1} + 6'd1;
        end
        f_out = key_fn(f_x, f_i, nk_m1);
        if (state == STEP)
            new_word = window[nk_m1] ^ f_out;
        else
            new_word = window[0] ^ f_out;
    end

    // Window shifts up when walking backward and down when walking forward.
    always_comb begin
        for (int k = 0; k < 8; k++)
            next_window[k] = window[k];
        if (state == STEP) begin
            next_window[0] = new_word;
            for (int k = 1; k < 8; k++)
                next_window[k] = window[k - 1];
        end else begin
            for (int k = 0; k < 7; k++)
                next_window[k] = window[k + 1];
            next_window[nk_m1] = new_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            for (int k = 0; k < 8; k++)
                window[k] <= '0;
            j         <= '0;
            nk_m1     <= '0;
            nr        <= '0;
            step_cnt  <= '0;
            round_idx <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (LOAD) begin
                for (int k = 0; k < 8; k++)
                    window[k] <= in_key[k*32 +: 32];
                j         <= '0;
                step_cnt  <= '0;
                key_valid <= 1'b0;
                state     <= EXPAND;
                case (mode)
                    2'd0: begin
                        nk_m1 <= 3'd3;
                        nr    <= 4'd10;
                    end
                    2'd1: begin
                        nk_m1 <= 3'd5;
                        nr    <= 4'd12;
                    end
                    default: begin
                        nk_m1 <= 3'd7;
                        nr    <= 4'd14;
                    end
                endcase
            end else begin
                case (state)
                    EXPAND: begin
                        if (j == last_j) begin
                            state     <= DELIVER;
                            key_valid <= 1'b1;
                            key_out   <= {window[0], window[1], window[2], window[3]};
                            round_idx <= nr;
                        end else begin
                            window <= next_window;
                            j      <= j + 6'd1;
                        end
                    end
                    DELIVER: begin
                        // After a walk, the first DELIVER cycle presents the new key.
                        if (!key_valid) begin
                            key_valid <= 1'b1;
                            key_out   <= {window[0], window[1], window[2], window[3]};
                        end else if (key_ready) begin
                            key_valid <= 1'b0;
                            if (round_idx == 4'd0) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state    <= STEP;
                                step_cnt <= '0;
                            end
                        end
                    end
                    STEP: begin
                        window   <= next_window;
                        j        <= j - 6'd1;
                        step_cnt <= step_cnt + 2'd1;
                        if (step_cnt == 2'd3) begin
                            round_idx <= round_idx - 4'd1;
                            state     <= DELIVER;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench: a full forward FIPS-197 expansion (S-box derived from
// GF(2^8) inversion) predicts every round key the DUT delivers, last to first.
module tb_aes_inv_key_schedule;
    logic         CLK = 1'b0;
    logic         RST;
    logic         LOAD;
    logic [1:0]   mode;
    logic [0:255] in_key;
    logic [0:127] key_out;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    aes_inv_key_schedule dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .mode(mode), .in_key(in_key),
        .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    localparam logic [0:255] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sbox_m [256];
    logic [31:0] w [64];
    int          exp_round = 0;
    int          keys_seen = 0;
    bit          armed = 0;
    bit          finished = 0;
    bit          exp_done = 0;
    bit          prev_stall = 0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        logic [7:0] r;
        for (int n = 0; n < 254; n++)
            inv = gmul(inv, a);
        s = inv;
        r = inv;
        for (int n = 0; n < 4; n++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    function automatic logic [0:127] model_key(input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic model_load(input logic [0:255] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 64; i++) begin
            if (i < nk) begin
                w[i] = key[i*32 +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Compare process: every cycle while a walk is armed.
    always @(negedge CLK) begin
        if (armed && !RST) begin
            checkOutput("done_pulse", 256'(done), 256'(exp_done));
            exp_done = 1'b0;
            if (finished)
                checkOutput("valid_after_done", 256'(key_valid), 256'(0));
            if (prev_stall)
                checkOutput("stall_valid_held", 256'(key_valid), 256'(1));
            if (key_valid && !finished) begin
                checkOutput("round_idx", 256'(round_idx), 256'(exp_round));
                checkOutput("key_out", 256'(key_out), 256'(model_key(exp_round)));
                if (key_ready) begin
                    keys_seen++;
                    if (exp_round == 0) begin
                        exp_done = 1'b1;
                        finished = 1'b1;
                    end else begin
                        exp_round--;
                    end
                end
            end
            prev_stall = key_valid && !key_ready;
        end
    end

    // Called #1 after a rising edge; LOAD is sampled at the next edge.
    task automatic applyStimulus(input logic [1:0] m, input logic [0:255] key, input int nk,
                                 input int nr, input logic [0:127] first_key);
        int cycles;
        mode   = m;
        in_key = key;
        LOAD   = 1'b1;
        @(posedge CLK);
        #1;
        LOAD   = 1'b0;
        mode   = ~m;
        in_key = ~key;
        model_load(key, nk);
        exp_round  = nr;
        keys_seen  = 0;
        finished   = 1'b0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
        armed      = 1'b1;
        checkOutput("model_first_key", 256'(model_key(nr)), 256'(first_key));
        checkOutput("valid_after_load", 256'(key_valid), 256'(0));
        checkOutput("busy_after_load", 256'(busy), 256'(1));
        cycles = 0;
        while (!key_valid && cycles < 200) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        checkOutput("first_latency", 256'(cycles), 256'(4*nr+1));
        checkOutput("first_round", 256'(round_idx), 256'(nr));
        checkOutput("first_key", 256'(key_out), 256'(first_key));
    endtask

    task automatic run_to_done(input int nr, input bit random_ready);
        int n = 0;
        while (!finished && n < 2000) begin
            @(posedge CLK);
            #1;
            key_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        checkOutput("walk_finished", 256'(finished), 256'(1));
        key_ready = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        checkOutput("keys_total", 256'(keys_seen), 256'(nr+1));
        checkOutput("busy_when_idle", 256'(busy), 256'(0));
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        while (!(key_valid && round_idx == 4'(r)) && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput("reached_round", 256'(round_idx), 256'(r));
    endtask

    initial begin
        for (int a = 0; a < 256; a++)
            sbox_m[a] = sbox_calc(8'(a));
        RST       = 1'b1;
        LOAD      = 1'b0;
        mode      = 2'd0;
        in_key    = '0;
        key_ready = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("reset_valid", 256'(key_valid), 256'(0));
        checkOutput("reset_done", 256'(done), 256'(0));
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_round", 256'(round_idx), 256'(0));
        checkOutput("reset_key", 256'(key_out), 256'(0));
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // AES-128, always ready
        key_ready = 1'b1;
        applyStimulus(2'd0, KEY128, 4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("model_128_round0", 256'(model_key(0)), 256'(KEY128[0:127]));
        run_to_done(10, 1'b0);

        // AES-192
        applyStimulus(2'd1, KEY192, 6, 12, 128'he98ba06f448c773c8ecc720401002202);
        checkOutput("model_192_round0", 256'(model_key(0)), 256'(KEY192[0:127]));
        run_to_done(12, 1'b0);

        // AES-256, mode 3 aliases mode 2
        applyStimulus(2'd3, KEY256, 8, 14, 128'hfe4890d1e6188d0b046df344706c631e);
        checkOutput("model_256_round1", 256'(model_key(1)), 256'(128'h1f352c073b6108d72d9810a30914dff4));
        run_to_done(14, 1'b0);

        // Backpressure: hold round 10 for 20 cycles, then random ready
        key_ready = 1'b0;
        applyStimulus(2'd0, KEY128, 4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (20) begin
            @(posedge CLK);
            #1;
        end
        checkOutput("bp_hold_round", 256'(round_idx), 256'(10));
        checkOutput("bp_hold_key", 256'(key_out), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        run_to_done(10, 1'b1);

        // Abort: AES-128 walk interrupted at round 7 by an AES-256 load
        key_ready = 1'b1;
        applyStimulus(2'd0, KEY128, 4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_round(7);
        applyStimulus(2'd2, KEY256, 8, 14, 128'hfe4890d1e6188d0b046df344706c631e);
        run_to_done(14, 1'b0);

        // Asynchronous reset during STEP, then a clean full walk
        applyStimulus(2'd0, KEY128, 4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_round(8);
        @(posedge CLK);
        #1;
        checkOutput("step_busy", 256'(busy), 256'(1));
        checkOutput("step_valid", 256'(key_valid), 256'(0));
        #2;
        armed = 1'b0;
        RST   = 1'b1;
        #1;
        checkOutput("async_rst_valid", 256'(key_valid), 256'(0));
        checkOutput("async_rst_busy", 256'(busy), 256'(0));
        checkOutput("async_rst_round", 256'(round_idx), 256'(0));
        checkOutput("async_rst_key", 256'(key_out), 256'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        applyStimulus(2'd0, KEY128, 4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_to_done(10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
